text_overlay: RTL
=================

// Module: text_overlay
// PURPOSE
//  Character-cell text overlay between the test pattern / sync generator and the HDMI video encoder.
//  Tracks raster position from blank/hsync/vsync and maps it to a 106x60 grid of 6x8 cells (5x7 glyphs).
//  Fetches the cell's code from an internal character RAM and its glyph row from font57_rom.
//  Keys FG_COLOR over the incoming RGB, delays sync/blank to match, and drives the video encoder.
// PARAMETERS
//  ADDR_W    13          char RAM address width; addr = {row[5:0], col[6:0]}
//  FG_COLOR  24'hFFFFFF  {r,g,b} for a set glyph pixel
//  BG_OPAQUE 1'b0        1: unset pixels inside text cells drive BG_COLOR; 0: pass input RGB
//  BG_COLOR  24'h000000  {r,g,b} for an unset pixel when BG_OPAQUE=1
// PORTS
//  clk       in   1  pixel clock
//  reset_n   in   1  asynchronous, active-low reset
//  blank_i   in   1  registered blanking from vga_sync
//  hsync_i   in   1  registered hsync
//  vsync_i   in   1  registered vsync
//  rgb_i     in  24  {red,green,blue} from test_pattern
//  text_en   in   1  1: overlay active; 0: rgb_o = delayed rgb_i
//  wr_en     in   1  char RAM write strobe
//  wr_addr   in  13  write address
//  wr_data   in   7  ASCII code
//  clear     in   1  one-cycle pulse: fill RAM with 0x20
//  busy      out  1  clear in progress; writes are ignored
//  blank_o   out  1  blank_i delayed by 3
//  hsync_o   out  1  hsync_i delayed by 3
//  vsync_o   out  1  vsync_i delayed by 3
//  rgb_o     out 24  composited pixel, aligned to the delayed sync
// BEHAVIOUR
//  Reset (async assert, sync release): all pipeline regs and outputs = 0; counters = 0.
//   FSM = CLEAR with clr_addr = 0, so busy = 1 straight out of reset.
//  Clear FSM, states IDLE / CLEAR:
//   IDLE  -> CLEAR when clear = 1; clr_addr <= 0.
//   CLEAR: writes 0x20 to clr_addr each cycle, then clr_addr++.
//   CLEAR -> IDLE after address 2^ADDR_W-1 is written, i.e. 8192 cycles.
//   clear asserted while in CLEAR is ignored. busy = (state == CLEAR).
//   Host writes are dropped while busy; otherwise wr_en writes wr_data at wr_addr in 1 cycle.
//  Position counters, stage 0:
//   px (0..5) and col (0..106) advance on each !blank_i cycle; px wraps 5 -> 0 and then col++.
//   px and col clear on every blank_i cycle.
//   On each rising edge of blank_i: ln (0..7) ++; ln wraps 7 -> 0 and then row++.
//   row is 6 bits and wraps mod 64.
//   vsync_i = 1 clears ln and row; vsync takes priority over the blank edge in the same cycle.
//   640 px = 106 full cells + 4 px of col 106. Col 106 reads {row,106}, which holds 0x20 after a clear.
//  Pipeline, fixed latency 3 for data and sync alike:
//   S1: char RAM synchronous read at {row,col}; px, ln, blank, sync, rgb registered alongside.
//   S2: font57_rom registered lookup (code, ln) -> 5-bit row.
//   S3: bit = (px<5 && ln<7) ? glyph[4-px] : 0 (bit 4 is the leftmost pixel).
//   S3 output select:
//    blank               -> rgb_o = 0
//    text_en=0           -> rgb_i
//    bit=1               -> FG_COLOR
//    else BG_OPAQUE=1    -> BG_COLOR
//    else                -> rgb_i
//  Read/write same address in the same cycle: the read returns OLD data; the write lands.
//  A clear write and a display read never conflict: display reads are on a separate port.
//  Codes outside 0x20..0x7E return glyph 0 (blank cell).
// STRUCTURE
//  Package text_overlay_pkg:
//   CELL_W=6, CELL_H=8, COLS=106, ROWS=60, SPACE=7'h20
//   typedef enum logic {IDLE, CLEAR} clr_state_t
//   typedef logic [4:0] glyph_row_t
//  Sub-module font57_rom: clk, code[6:0], line[2:0] -> glyph_row_t, 1-cycle registered case ROM.
//  Char RAM: simple dual-port, inferred inline (write port muxed between host and clear FSM).
// TESTING
//  1 Reset release: busy = 1 for exactly 8192 clk, then 0; blank_o/hsync_o/vsync_o/rgb_o held 0 during reset.
//  2 Latency: apply a single-cycle hsync_i pulse at cycle N -> hsync_o pulses at cycle N+3 (same for blank_i and vsync_i).
//  3 Glyph: after the clear, write 0x41 ('A') at addr 0; run a 640x480 frame with rgb_i = 24'h102030.
//     Line 0: x = 1..3 -> FFFFFF; x = 0, 4, 5 -> 102030.
//  4 text_en = 0, same frame -> rgb_o equals rgb_i delayed by 3 on every active pixel.
//     With BG_OPAQUE=1 and text_en=1, empty cells -> 000000.
//  5 Collision and guarding:
//     wr_en with wr_addr = display read address in the same cycle -> the old code is displayed that cycle,
//     the new code from the next frame.
//     wr_en while busy -> RAM unchanged (reads 0x20).
//  6 Reset mid-clear: deassert reset_n at clr_addr = 3000 -> busy restarts and completes after 8192 cycles.
//     Col 106 pixels 636..639 show blank (space) cells.

Source files
------------

// File: rtl/text_overlay_pkg.sv
`default_nettype none
// ============================================================================
// Module      : text_overlay_pkg
// Description : Shared cell geometry, clear-FSM states and glyph row type.
// Revision    : 1.0
// ============================================================================
package text_overlay_pkg;

    localparam int         CELL_W = 6;
    localparam int         CELL_H = 8;
    localparam int         COLS   = 106;
    localparam int         ROWS   = 60;
    localparam logic [6:0] SPACE  = 7'h20;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    typedef logic [4:0] glyph_row_t;

endpackage
`default_nettype wire

// File: rtl/font57_rom.sv
`default_nettype none
// ============================================================================
// Module      : font57_rom
// Description : 5x7 glyph ROM for ASCII 0x20..0x7E, one registered row per clk.
// Revision    : 1.0
// ============================================================================
module font57_rom
    import text_overlay_pkg::*;
(
    input  logic       clk,
    input  logic [6:0] code,
    input  logic [2:0] line,
    output glyph_row_t glyph
);

    // Five column bytes, leftmost first; bit 0 of each byte is the top line.
    logic [39:0] cols;
    logic [7:0]  c0, c1, c2, c3, c4;

    assign {c0, c1, c2, c3, c4} = cols;

    always_comb begin
        cols = '0;
        case (code)
            7'h20: cols = 40'h00_00_00_00_00;  7'h21: cols = 40'h00_00_5F_00_00;
            7'h22: cols = 40'h00_07_00_07_00;  7'h23: cols = 40'h14_7F_14_7F_14;
            7'h24: cols = 40'h24_2A_7F_2A_12;  7'h25: cols = 40'h23_13_08_64_62;
            7'h26: cols = 40'h36_49_55_22_50;  7'h27: cols = 40'h00_05_03_00_00;
            7'h28: cols = 40'h00_1C_22_41_00;  7'h29: cols = 40'h00_41_22_1C_00;
            7'h2A: cols = 40'h08_2A_1C_2A_08;  7'h2B: cols = 40'h08_08_3E_08_08;
            7'h2C: cols = 40'h00_50_30_00_00;  7'h2D: cols = 40'h08_08_08_08_08;
            7'h2E: cols = 40'h00_60_60_00_00;  7'h2F: cols = 40'h20_10_08_04_02;
            7'h30: cols = 40'h3E_51_49_45_3E;  7'h31: cols = 40'h00_42_7F_40_00;
            7'h32: cols = 40'h42_61_51_49_46;  7'h33: cols = 40'h21_41_45_4B_31;
            7'h34: cols = 40'h18_14_12_7F_10;  7'h35: cols = 40'h27_45_45_45_39;
            7'h36: cols = 40'h3C_4A_49_49_30;  7'h37: cols = 40'h01_71_09_05_03;
            7'h38: cols = 40'h36_49_49_49_36;  7'h39: cols = 40'h06_49_49_29_1E;
            7'h3A: cols = 40'h00_36_36_00_00;  7'h3B: cols = 40'h00_56_36_00_00;
            7'h3C: cols = 40'h00_08_14_22_41;  7'h3D: cols = 40'h14_14_14_14_14;
            7'h3E: cols = 40'h41_22_14_08_00;  7'h3F: cols = 40'h02_01_51_09_06;
            7'h40: cols = 40'h32_49_79_41_3E;  7'h41: cols = 40'h7E_11_11_11_7E;
            7'h42: cols = 40'h7F_49_49_49_36;  7'h43: cols = 40'h3E_41_41_41_22;
            7'h44: cols = 40'h7F_41_41_22_1C;  7'h45: cols = 40'h7F_49_49_49_41;
            7'h46: cols = 40'h7F_09_09_01_01;  7'h47: cols = 40'h3E_41_41_51_32;
            7'h48: cols = 40'h7F_08_08_08_7F;  7'h49: cols = 40'h00_41_7F_41_00;
            7'h4A: cols = 40'h20_40_41_3F_01;  7'h4B: cols = 40'h7F_08_14_22_41;
            7'h4C: cols = 40'h7F_40_40_40_40;  7'h4D: cols = 40'h7F_02_04_02_7F;
            7'h4E: cols = 40'h7F_04_08_10_7F;  7'h4F: cols = 40'h3E_41_41_41_3E;
            7'h50: cols = 40'h7F_09_09_09_06;  7'h51: cols = 40'h3E_41_51_21_5E;
            7'h52: cols = 40'h7F_09_19_29_46;  7'h53: cols = 40'h46_49_49_49_31;
            7'h54: cols = 40'h01_01_7F_01_01;  7'h55: cols = 40'h3F_40_40_40_3F;
            7'h56: cols = 40'h1F_20_40_20_1F;  7'h57: cols = 40'h7F_20_18_20_7F;
            7'h58: cols = 40'h63_14_08_14_63;  7'h59: cols = 40'h03_04_78_04_03;
            7'h5A: cols = 40'h61_51_49_45_43;  7'h5B: cols = 40'h00_00_7F_41_41;
            7'h5C: cols = 40'h02_04_08_10_20;  7'h5D: cols = 40'h41_41_7F_00_00;
            7'h5E: cols = 40'h04_02_01_02_04;  7'h5F: cols = 40'h40_40_40_40_40;
            7'h60: cols = 40'h00_01_02_04_00;  7'h61: cols = 40'h20_54_54_54_78;
            7'h62: cols = 40'h7F_48_44_44_38;  7'h63: cols = 40'h38_44_44_44_20;
            7'h64: cols = 40'h38_44_44_48_7F;  7'h65: cols = 40'h38_54_54_54_18;
            7'h66: cols = 40'h08_7E_09_01_02;  7'h67: cols = 40'h08_14_54_54_3C;
            7'h68: cols = 40'h7F_08_04_04_78;  7'h69: cols = 40'h00_44_7D_40_00;
            7'h6A: cols = 40'h20_40_44_3D_00;  7'h6B: cols = 40'h00_7F_10_28_44;
            7'h6C: cols = 40'h00_41_7F_40_00;  7'h6D: cols = 40'h7C_04_18_04_78;
            7'h6E: cols = 40'h7C_08_04_04_78;  7'h6F: cols = 40'h38_44_44_44_38;
            7'h70: cols = 40'h7C_14_14_14_08;  7'h71: cols = 40'h08_14_14_18_7C;
            7'h72: cols = 40'h7C_08_04_04_08;  7'h73: cols = 40'h48_54_54_54_20;
            7'h74: cols = 40'h04_3F_44_40_20;  7'h75: cols = 40'h3C_40_40_20_7C;
            7'h76: cols = 40'h1C_20_40_20_1C;  7'h77: cols = 40'h3C_40_30_40_3C;
            7'h78: cols = 40'h44_28_10_28_44;  7'h79: cols = 40'h0C_50_50_50_3C;
            7'h7A: cols = 40'h44_64_54_4C_44;  7'h7B: cols = 40'h00_08_36_41_00;
            7'h7C: cols = 40'h00_00_7F_00_00;  7'h7D: cols = 40'h00_41_36_08_00;
            7'h7E: cols = 40'h08_04_08_10_08;
            default: cols = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        glyph <= {c0[line], c1[line], c2[line], c3[line], c4[line]};
    end

endmodule
`default_nettype wire

// File: rtl/text_overlay.sv
`default_nettype none
// ============================================================================
// Module      : text_overlay
// Description : 106x60 character-cell overlay keyed over RGB video, latency 3.
// Revision    : 1.0
// ============================================================================
module text_overlay
    import text_overlay_pkg::*;
#(
    parameter int          ADDR_W    = 13,
    parameter logic [23:0] FG_COLOR  = 24'hFFFFFF,
    parameter bit          BG_OPAQUE = 1'b0,
    parameter logic [23:0] BG_COLOR  = 24'h000000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              blank_i,
    input  logic              hsync_i,
    input  logic              vsync_i,
    input  logic [23:0]       rgb_i,
    input  logic              text_en,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [6:0]        wr_data,
    input  logic              clear,
    output logic              busy,
    output logic              blank_o,
    output logic              hsync_o,
    output logic              vsync_o,
    output logic [23:0]       rgb_o
);

    clr_state_t        state, state_next;
    logic [ADDR_W-1:0] clr_addr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= CLEAR;
            clr_addr <= '0;
        end else begin
            state <= state_next;
            if (state == CLEAR)
                clr_addr <= clr_addr + 1'b1;
            else if (clear)
                clr_addr <= '0;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (clear) state_next = CLEAR;
            CLEAR: if (&clr_addr) state_next = IDLE;
        endcase
    end

    assign busy = (state == CLEAR);

    // The clear sweep owns the write port; host writes are dropped meanwhile.
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr, rd_addr;
    logic [6:0]        ram_wdata, s1_code;
    logic [6:0]        char_ram [2**ADDR_W];

    always_comb begin
        ram_we    = wr_en;
        ram_waddr = wr_addr;
        ram_wdata = wr_data;
        if (busy) begin
            ram_we    = 1'b1;
            ram_waddr = clr_addr;
            ram_wdata = SPACE;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we)
            char_ram[ram_waddr] <= ram_wdata;
        s1_code <= char_ram[rd_addr];
    end

    logic [2:0] px, ln;
    logic [6:0] col;
    logic [5:0] row;
    logic       blank_q;

    assign rd_addr = ADDR_W'({row, col});

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            px      <= '0;
            col     <= '0;
            ln      <= '0;
            row     <= '0;
            blank_q <= 1'b0;
        end else begin
            blank_q <= blank_i;
            if (blank_i) begin
                px  <= '0;
                col <= '0;
            end else if (px == 3'(CELL_W - 1)) begin
                px  <= '0;
                col <= col + 1'b1;
            end else begin
                px <= px + 1'b1;
            end
            // Lines advance at the end of each active line; vsync re-homes the raster.
            if (vsync_i) begin
                ln  <= '0;
                row <= '0;
            end else if (blank_i && !blank_q) begin
                if (ln == 3'(CELL_H - 1)) begin
                    ln  <= '0;
                    row <= row + 1'b1;
                end else begin
                    ln <= ln + 1'b1;
                end
            end
        end
    end

    logic [2:0]  s1_px, s1_ln, s2_px, s2_ln;
    logic [2:0]  s1_sync, s2_sync;          // {blank, hsync, vsync}
    logic [23:0] s1_rgb, s2_rgb;
    glyph_row_t  s2_glyph;

    font57_rom u_font (
        .clk   (clk),
        .code  (s1_code),
        .line  (s1_ln),
        .glyph (s2_glyph)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_px   <= '0;
            s1_ln   <= '0;
            s1_sync <= '0;
            s1_rgb  <= '0;
            s2_px   <= '0;
            s2_ln   <= '0;
            s2_sync <= '0;
            s2_rgb  <= '0;
        end else begin
            s1_px   <= px;
            s1_ln   <= ln;
            s1_sync <= {blank_i, hsync_i, vsync_i};
            s1_rgb  <= rgb_i;
            s2_px   <= s1_px;
            s2_ln   <= s1_ln;
            s2_sync <= s1_sync;
            s2_rgb  <= s1_rgb;
        end
    end

    logic        pix_on;
    logic [23:0] pix_rgb;

    // Sixth column and eighth line of each cell are the inter-glyph gap.
    always_comb begin
        pix_on = 1'b0;
        if (s2_px < 3'(CELL_W - 1) && s2_ln < 3'(CELL_H - 1))
            pix_on = s2_glyph[3'd4 - s2_px];
    end

    always_comb begin
        pix_rgb = s2_rgb;
        if (s2_sync[2])
            pix_rgb = '0;
        else if (!text_en)
            pix_rgb = s2_rgb;
        else if (pix_on)
            pix_rgb = FG_COLOR;
        else if (BG_OPAQUE)
            pix_rgb = BG_COLOR;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blank_o <= 1'b0;
            hsync_o <= 1'b0;
            vsync_o <= 1'b0;
            rgb_o   <= '0;
        end else begin
            {blank_o, hsync_o, vsync_o} <= s2_sync;
            rgb_o                       <= pix_rgb;
        end
    end

endmodule
`default_nettype wire
